// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use stalls,
// MEM-stage branch flushes, multi-cycle data-memory freeze, and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_mem_read,
    input  logic             exmem_mem_write,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             pcsrc,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } state_e;

    state_e           state_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic             err_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic req;
    logic taken;
    logic lu;
    logic in_err;
    logic freeze;
    logic do_flush;
    logic do_lu;
    logic wait_last;

    always_comb begin
        req       = exmem_mem_read | exmem_mem_write;
        taken     = exmem_branch & exmem_zero;
        lu        = idex_mem_read & (idex_rt != 5'd0) &
                    ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));
        in_err    = (state_q == StError);
        freeze    = ((state_q == StRun) & req & ~dmem_ack) |
                    ((state_q == StMemWait) & ~dmem_ack);
        // Branch and load-use only act when the pipeline is actually advancing.
        do_flush  = ~in_err & ~freeze & taken;
        do_lu     = ~in_err & ~freeze & ~taken & lu;
        wait_last = (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1));
    end

    always_comb begin
        dmem_req     = 1'b0;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        pcsrc        = 1'b0;
        if (rst_n) begin
            dmem_req    = req & ~in_err;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            if (in_err || freeze) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
            end else if (do_flush) begin
                pcsrc       = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (do_lu) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (req && !dmem_ack) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= '0;
                    end
                end
                StMemWait: begin
                    if (dmem_ack) begin
                        state_q <= StRun;
                    end else if (wait_last) begin
                        state_q <= StError;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((freeze || do_lu) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (do_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign err       = err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table of single-cycle vectors plus
// hand-written multi-cycle sequences, outputs checked through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

    // Output vector: {dmem_req, pc_write, ifid_write, idex_write, exmem_write,
    //                 ifid_flush, idex_flush, exmem_flush, memwb_bubble, pcsrc, err}
    localparam logic [10:0] O_DEF = 11'b0_1111_000_00_0;
    localparam logic [10:0] O_LU  = 11'b0_0011_010_00_0;
    localparam logic [10:0] O_TK  = 11'b0_1111_111_01_0;
    localparam logic [10:0] O_FRZ = 11'b1_0000_000_10_0;
    localparam logic [10:0] O_ERR = 11'b0_0000_000_10_1;
    localparam logic [10:0] O_REQ = 11'b1_0000_000_00_0;
    localparam logic [10:0] O_RST = 11'b0_0000_000_00_0;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic        idex_mr;
        logic [4:0]  idex_rt;
        logic        br;
        logic        zero;
        logic        mr;
        logic        mw;
        logic        ack;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        logic [10:0] exp;
        string       name;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
    logic       id_uses_rt = 1'b0, idex_mem_read = 1'b0;
    logic       exmem_branch = 1'b0, exmem_zero = 1'b0;
    logic       exmem_mem_read = 1'b0, exmem_mem_write = 1'b0, dmem_ack = 1'b0;
    logic       dmem_req, pc_write, ifid_write, idex_write, exmem_write;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble, pcsrc, err;
    logic [3:0] stall_cnt, flush_cnt;

    int   n_vec = 0;
    int   n_bad = 0;
    sb_t  sbq[$];
    vec_t tbl[12];

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .idex_mem_read  (idex_mem_read),
        .idex_rt        (idex_rt),
        .exmem_branch   (exmem_branch),
        .exmem_zero     (exmem_zero),
        .exmem_mem_read (exmem_mem_read),
        .exmem_mem_write(exmem_mem_write),
        .dmem_ack       (dmem_ack),
        .dmem_req       (dmem_req),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .idex_write     (idex_write),
        .exmem_write    (exmem_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .memwb_bubble   (memwb_bubble),
        .pcsrc          (pcsrc),
        .err            (err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                 input logic imr, input logic [4:0] irt, input logic br,
                                 input logic z, input logic mr, input logic mw, input logic ack,
                                 input logic [10:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses; v.idex_mr = imr; v.idex_rt = irt;
        v.br = br; v.zero = z; v.mr = mr; v.mw = mw; v.ack = ack; v.exp = exp;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {dmem_req, pc_write, ifid_write, idex_write, exmem_write,
                ifid_flush, idex_flush, exmem_flush, memwb_bubble, pcsrc, err};
    endfunction

    task automatic check_outs(input logic [10:0] exp, input string name);
        n_vec++;
        if (outs() !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %b, expected %b", name, outs(), exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (caller sits just after a rising edge), check mid-cycle,
    // and return just after the edge that consumes them.
    task automatic apply(input vec_t v, input string name);
        sb_t s;
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
        idex_mem_read = v.idex_mr; idex_rt = v.idex_rt;
        exmem_branch = v.br; exmem_zero = v.zero;
        exmem_mem_read = v.mr; exmem_mem_write = v.mw; dmem_ack = v.ack;
        sbq.push_back('{exp: v.exp, name: name});
        @(negedge clk);
        if (sbq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            s = sbq.pop_front();
            check_outs(s.exp, s.name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        vec_t idle;
        idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
        id_rs = idle.rs; id_rt = idle.rt; id_uses_rt = 0; idex_mem_read = 0; idex_rt = 0;
        exmem_branch = 0; exmem_zero = 0; exmem_mem_read = 0; exmem_mem_write = 0;
        dmem_ack = 0;
        rst_n = 1'b0;
        #2;
        check_outs(O_RST, {name, "_outs"});
        check_cnt({name, "_stall_cnt"}, stall_cnt, 4'd0);
        check_cnt({name, "_flush_cnt"}, flush_cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   exp_stall;
        int   exp_flush;

        tbl[0]  = mkv(5'd1, 5'd4, 1, 0, 5'd0, 0, 0, 0, 0, 0, O_DEF);
        tbl[1]  = mkv(5'd2, 5'd7, 0, 1, 5'd2, 0, 0, 0, 0, 0, O_LU);
        tbl[2]  = mkv(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, 0, O_DEF);
        tbl[3]  = mkv(5'd1, 5'd3, 0, 1, 5'd3, 0, 0, 0, 0, 0, O_DEF);
        tbl[4]  = mkv(5'd1, 5'd3, 1, 1, 5'd3, 0, 0, 0, 0, 0, O_LU);
        tbl[5]  = mkv(5'd6, 5'd6, 1, 0, 5'd6, 0, 0, 0, 0, 0, O_DEF);
        tbl[6]  = mkv(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0, 0, O_TK);
        tbl[7]  = mkv(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 0, O_DEF);
        tbl[8]  = mkv(5'd9, 5'd0, 0, 1, 5'd9, 1, 1, 0, 0, 0, O_TK);
        tbl[9]  = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, O_DEF | O_REQ);
        tbl[10] = mkv(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 1, 1, O_LU | O_REQ);
        tbl[11] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, O_DEF);

        do_reset("reset");

        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i], $sformatf("table[%0d]", i));
            if (tbl[i].exp[9] == 1'b0) exp_stall++;
            if (tbl[i].exp[1] == 1'b1) exp_flush++;
        end
        check_cnt("table_stall_cnt", stall_cnt, 4'(exp_stall));
        check_cnt("table_flush_cnt", flush_cnt, 4'(exp_flush));

        // Memory wait of 3 cycles with a load-use and a branch arriving during the freeze.
        do_reset("reset_memwait");
        apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ), "memwait_c1");
        apply(mkv(5'd2, 0, 0, 1, 5'd2, 0, 0, 0, 1, 0, O_FRZ), "memwait_c2_lu");
        apply(mkv(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, O_FRZ), "memwait_c3_br");
        apply(mkv(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, O_TK | O_REQ), "memwait_ack_br");
        check_cnt("memwait_stall_cnt", stall_cnt, 4'd3);
        check_cnt("memwait_flush_cnt", flush_cnt, 4'd1);
        apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF), "memwait_after");

        // Timeout: 5 un-acked cycles, then ERROR absorbs even with ack.
        do_reset("reset_timeout");
        v = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ);
        for (int i = 0; i < 5; i++) apply(v, $sformatf("timeout_wait%0d", i));
        v.exp = O_ERR;
        apply(v, "error_c1");
        apply(v, "error_c2");
        v.ack = 1'b1;
        apply(v, "error_ack");
        check_cnt("timeout_stall_cnt", stall_cnt, 4'd5);
        rst_n = 1'b0;
        #1;
        check_outs(O_RST, "rst_in_error_outs");
        check_cnt("rst_in_error_stall", stall_cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v.ack = 1'b0;
        v.exp = O_FRZ;
        apply(v, "after_error_freeze");
        v.ack = 1'b1;
        v.exp = O_DEF | O_REQ;
        apply(v, "after_error_ack");

        // Counter saturation.
        do_reset("reset_sat");
        for (int i = 0; i < 20; i++)
            apply(mkv(5'd2, 0, 0, 1, 5'd2, 0, 0, 0, 0, 0, O_LU), $sformatf("sat_lu%0d", i));
        check_cnt("sat_stall_cnt", stall_cnt, 4'd15);
        for (int i = 0; i < 17; i++)
            apply(mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, O_TK), $sformatf("sat_tk%0d", i));
        check_cnt("sat_flush_cnt", flush_cnt, 4'd15);

        n_vec++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
